// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI responder: FSM states and command bit layout.
package adc_spi_pkg;

  localparam int unsigned DEFAULT_DATA_W = 12;
  localparam int unsigned CMD_BITS       = 3;
  localparam int unsigned CMD_SGL        = 0;
  localparam int unsigned CMD_ODD        = 1;
  localparam int unsigned CMD_MSBF       = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    NULL,
    DATA_MSB,
    DATA_LSB,
    DONE
  } state_e;

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pins, channel stand-in values and frame status of the ADC responder.
interface adc_spi_responder_if #(
  parameter int unsigned DATA_W = adc_spi_pkg::DEFAULT_DATA_W
);
  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic [DATA_W-1:0] ch0_data;
  logic [DATA_W-1:0] ch1_data;
  logic              miso;
  logic              miso_oe;
  logic              busy;
  logic              cfg_sgl;
  logic              cfg_odd;
  logic              cfg_msbf;
  logic              frame_done;
  logic              frame_abort;

  modport master (
    output cs_n, sclk, mosi, ch0_data, ch1_data,
    input  miso, miso_oe, busy, cfg_sgl, cfg_odd, cfg_msbf, frame_done, frame_abort
  );

  modport slave (
    input  cs_n, sclk, mosi, ch0_data, ch1_data,
    output miso, miso_oe, busy, cfg_sgl, cfg_odd, cfg_msbf, frame_done, frame_abort
  );
endinterface

// File: rtl/spi_sig_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall pulses from the last stage.
module spi_sig_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_c_o,
  output logic fall_c_o
);
  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign q_o      = sync_q[STAGES-1];
  assign rise_c_o =  sync_q[STAGES-1] & ~dly_q;
  assign fall_c_o = ~sync_q[STAGES-1] &  dly_q;
endmodule

// File: rtl/adc_spi_responder.sv
// SPI-slave twin of the 12-bit 2-channel ADC: decodes start/SGL/ODD/MSBF and
// shifts out a null bit plus the selected conversion, optionally with an LSB-first tail.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  adc_spi_responder_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(bus.cs_n),
    .q_o(cs_lvl), .rise_c_o(cs_rise), .fall_c_o(cs_fall));
  spi_sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(bus.sclk),
    .q_o(sclk_lvl), .rise_c_o(sclk_rise), .fall_c_o(sclk_fall));
  spi_sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(bus.mosi),
    .q_o(mosi_lvl), .rise_c_o(mosi_rise), .fall_c_o(mosi_fall));

  assign unused_sync = ^{cs_lvl, sclk_lvl, mosi_rise, mosi_fall};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [CMD_BITS-1:0] cfg_q, cfg_d;
  logic                miso_q, miso_d;
  logic                miso_oe_q, miso_oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;

  // Differences carry one extra bit so a negative result is detected, not wrapped.
  logic [DATA_W:0]   diff01_c, diff10_c;
  logic [DATA_W-1:0] conv_c;

  assign diff01_c = {1'b0, bus.ch0_data} - {1'b0, bus.ch1_data};
  assign diff10_c = {1'b0, bus.ch1_data} - {1'b0, bus.ch0_data};

  always_comb begin
    conv_c = bus.ch0_data;
    case ({cfg_q[CMD_SGL], cfg_q[CMD_ODD]})
      2'b10:   conv_c = bus.ch0_data;
      2'b11:   conv_c = bus.ch1_data;
      2'b00:   conv_c = diff01_c[DATA_W] ? '0 : diff01_c[DATA_W-1:0];
      default: conv_c = diff10_c[DATA_W] ? '0 : diff10_c[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sample_q  <= '0;
      cfg_q     <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      cfg_q     <= cfg_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  // CS rise overrides any coincident sclk edge and ends the frame from every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    cfg_d     = cfg_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;

    if (cs_rise) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      busy_d    = 1'b0;
      abort_d   = state_q inside {CMD, NULL, DATA_MSB, DATA_LSB};
    end else begin
      case (state_q)
        IDLE: begin
          miso_oe_d = 1'b0;
          busy_d    = 1'b0;
          if (cs_fall) state_d = WAIT_START;
        end
        WAIT_START: begin
          if (sclk_rise && mosi_lvl) begin
            state_d = CMD;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cfg_d[cnt_q[1:0]] = mosi_lvl;
            if (cnt_q == CNT_W'(CMD_MSBF)) begin
              sample_d = conv_c;
              state_d  = NULL;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        NULL: begin
          if (sclk_fall) begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b1;
            cnt_d     = CNT_W'(DATA_W - 1);
            state_d   = DATA_MSB;
          end
        end
        DATA_MSB: begin
          if (sclk_fall) begin
            miso_d = sample_q[cnt_q];
            if (cnt_q == '0) begin
              if (cfg_q[CMD_MSBF]) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = DATA_LSB;
                cnt_d   = CNT_W'(1);
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        DATA_LSB: begin
          if (sclk_fall) begin
            miso_d = sample_q[cnt_q];
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (sclk_fall) miso_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.busy        = busy_q;
  assign bus.cfg_sgl     = cfg_q[CMD_SGL];
  assign bus.cfg_odd     = cfg_q[CMD_ODD];
  assign bus.cfg_msbf    = cfg_q[CMD_MSBF];
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
endmodule
